// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the IF/ID and ID/EX stage registers: load-use stall,
// branch flush, and halt drain, with a saturating load-use stall counter.
module hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_ld,
  input  logic [4:0]       ex_rd,
  input  logic             ex_halt,
  input  logic             branch_taken,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexNop,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DRAIN_W-1:0] r_drain;
  logic [DRAIN_W-1:0] w_drain_nxt;
  logic [CNT_W-1:0]   r_stall;
  logic               w_luh;
  logic               w_stall_inc;

  // Load in EX writes a register the ID instruction actually reads (x0 never hazards)
  assign w_luh = ex_ld & (ex_rd != 5'd0) &
                 ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // State, drain counter and stall counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_drain <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= w_drain_nxt;
      if (w_stall_inc && (r_stall != '1)) begin
        r_stall <= r_stall + CNT_W'(1);
      end
    end
  end

  // Next state and combinational stage controls; defaults hold the pipeline frozen
  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain;
    w_stall_inc = 1'b0;
    pcWrite     = 1'b0;
    ifidWrite   = 1'b0;
    ifidFlush   = 1'b1;
    idexNop     = 1'b1;
    halted      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (ex_halt) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = DRAIN_W'(DRAIN_CYCLES - 1);
        end else if (branch_taken) begin
          pcWrite   = 1'b1;
          ifidWrite = 1'b1;
        end else if (w_luh) begin
          ifidFlush   = 1'b0;
          w_stall_inc = 1'b1;
        end else begin
          pcWrite   = 1'b1;
          ifidWrite = 1'b1;
          ifidFlush = 1'b0;
          idexNop   = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (r_drain == '0) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_drain_nxt = r_drain - DRAIN_W'(1);
        end
      end
      ST_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        // Illegal code: look parked, then recover to RUN
        halted      = 1'b1;
        w_state_nxt = ST_RUN;
      end
    endcase
    if (reset) begin
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
      ifidFlush = 1'b1;
      idexNop   = 1'b1;
      halted    = 1'b0;
    end
  end

  assign state        = r_state;
  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed cases plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int unsigned DRAIN_CYCLES = 3;
  localparam int unsigned CNT_W        = 16;
  localparam longint      CNT_MAX      = (64'd1 << CNT_W) - 1;

  logic             clock;
  logic             reset;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_ld;
  logic [4:0]       ex_rd;
  logic             ex_halt;
  logic             branch_taken;
  logic             pcWrite;
  logic             ifidWrite;
  logic             ifidFlush;
  logic             idexNop;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;

  hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_ld(ex_ld), .ex_rd(ex_rd), .ex_halt(ex_halt), .branch_taken(branch_taken),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
    .idexNop(idexNop), .halted(halted), .state(state), .stall_cycles(stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: mode 0=running, 1=draining, 2=parked; m_left = drain cycles still to spend
  int     m_mode;
  int     m_left;
  longint m_stalls;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_luh();
    return ex_ld && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic longint exp_stalls();
    return (m_stalls > CNT_MAX) ? CNT_MAX : m_stalls;
  endfunction

  task automatic model_reset();
    m_mode   = 0;
    m_left   = 0;
    m_stalls = 0;
  endtask

  // One clock: check combinational outputs mid-cycle, then advance model at the edge
  task automatic step();
    bit e_pc, e_ifid, e_fl, e_nop, e_h;
    e_pc = 0; e_ifid = 0; e_fl = 1; e_nop = 1; e_h = (m_mode == 2);
    if (m_mode == 0) begin
      if (ex_halt)           begin e_pc = 0; e_ifid = 0; e_fl = 1; e_nop = 1; end
      else if (branch_taken) begin e_pc = 1; e_ifid = 1; e_fl = 1; e_nop = 1; end
      else if (model_luh())  begin e_pc = 0; e_ifid = 0; e_fl = 0; e_nop = 1; end
      else                   begin e_pc = 1; e_ifid = 1; e_fl = 0; e_nop = 0; end
    end
    @(negedge clock);
    chk("pcWrite",      pcWrite,      e_pc);
    chk("ifidWrite",    ifidWrite,    e_ifid);
    chk("ifidFlush",    ifidFlush,    e_fl);
    chk("idexNop",      idexNop,      e_nop);
    chk("halted",       halted,       e_h);
    chk("state",        state,        m_mode);
    chk("stall_cycles", stall_cycles, exp_stalls());
    @(posedge clock);
    if (m_mode == 0) begin
      if (ex_halt) begin
        m_mode = 1;
        m_left = DRAIN_CYCLES;
      end else if (!branch_taken && model_luh()) begin
        m_stalls++;
      end
    end else if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) m_mode = 2;
    end
    #1;
  endtask

  // Asynchronous reset pulse, checked while still asserted and before any edge
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_state"},  state,        0);
    chk({tag, "_halted"}, halted,       0);
    chk({tag, "_pc"},     pcWrite,      0);
    chk({tag, "_ifid"},   ifidWrite,    0);
    chk({tag, "_flush"},  ifidFlush,    1);
    chk({tag, "_nop"},    idexNop,      1);
    chk({tag, "_stall"},  stall_cycles, 0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_ld = 0; ex_rd = 0; ex_halt = 0; branch_taken = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    pulse_reset("init");

    // Load x5 then add x6,x5,x1
    ex_ld = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 1; id_use_rs2 = 1;
    step();
    chk("luh_count", stall_cycles, 1);
    ex_ld = 0;
    step();
    chk("after_luh_pc", pcWrite, 1);

    // x0 destination never stalls
    ex_ld = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    step();
    chk("x0_count", stall_cycles, 1);

    // rs2 matches but is not read
    ex_rd = 5; id_rs1 = 3; id_rs2 = 5; id_use_rs2 = 0;
    step();

    // Branch outranks a load-use hazard
    id_use_rs2 = 1; branch_taken = 1;
    step();
    chk("br_luh_count", stall_cycles, 1);

    // Halt pulse, branch during drain ignored
    idle_inputs();
    ex_halt = 1;
    step();
    ex_halt = 0; branch_taken = 1;
    for (int i = 0; i < DRAIN_CYCLES; i++) step();
    branch_taken = 0;
    chk("parked_state", state, 2);
    step();
    step();
    pulse_reset("halted_rst");
    step();

    // Randomized traffic with small register range to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_use_rs1   = 1'($urandom_range(0, 1));
      id_use_rs2   = 1'($urandom_range(0, 1));
      ex_ld        = 1'($urandom_range(0, 1));
      ex_rd        = 5'($urandom_range(0, 3));
      ex_halt      = ($urandom_range(0, 39) == 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      if ((m_mode == 2 && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) begin
        if ($urandom_range(0, 1) == 1) #2;
        pulse_reset("rand_rst");
      end else begin
        step();
      end
    end

    // Saturation of the stall counter
    idle_inputs();
    pulse_reset("sat_rst");
    ex_ld = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    repeat ((1 << CNT_W) + 2) begin
      @(posedge clock);
      m_stalls++;
    end
    #1;
    chk("sat_value", stall_cycles, 16'hFFFF);
    step();
    chk("sat_hold", stall_cycles, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
